i2c_target_regfile: RTL and testbench

- Synthesizable I2C target (slave) holding a NUM_REGS x 8-bit register file, addressed through a pointer byte.
- Sits behind the shared open-drain bus: the DUT drives SDA low only, and the bus pull-up provides the high level.
- A local host port gives read access and sees a strobe on every I2C write.
- First RTL target for the existing UVC agent and interface.

---
 rtl/i2c_pkg.sv | 10 +
 rtl/i2c_line_filter.sv | 35 +++
 rtl/i2c_target_regfile.sv | 140 ++++++++++++++
 tb/tb_i2c_target_regfile.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding and I2C protocol constants for the register-file target.
package i2c_pkg;
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE
    } i2c_tgt_state_e;
    localparam logic I2C_ACK = 1'b0;
    localparam logic I2C_NACK = 1'b1;
    localparam logic [6:0] GEN_CALL_ADDR = 7'h00;
    localparam logic [7:0] GEN_CALL_RESET = 8'h06;
endpackage

// File: rtl/i2c_line_filter.sv
// i2c_line_filter: 2-flop synchroniser, FILTER_LEN-sample stability filter and edge strobes.
module i2c_line_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic system_clock,
    input  logic reset_n,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);
    localparam int CW = $clog2(FILTER_LEN + 1);
    logic [1:0] sync;
    logic prev;
    logic [CW-1:0] cnt;
    // Idle bus reads high, so the filtered level starts at 1 to avoid a false edge out of reset.
    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            sync <= 2'b11;
            level <= 1'b1;
            prev <= 1'b1;
            cnt <= '0;
        end else begin
            sync <= {sync[0], pin};
            prev <= level;
            if (sync[1] == level) cnt <= '0;
            else if (cnt == CW'(FILTER_LEN - 1)) begin
                level <= sync[1];
                cnt <= '0;
            end else cnt <= cnt + 1'b1;
        end
    end
    assign rise = level & ~prev;
    assign fall = ~level & prev;
endmodule

// File: rtl/i2c_target_regfile.sv
// i2c_target_regfile: I2C target exposing a pointer-addressed register file to a local host.
// Optional general-call register reset is enabled by defining I2C_GENERAL_CALL_EN.
module i2c_target_regfile
    import i2c_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = 7'h50,
    parameter int NUM_REGS = 16,
    parameter int FILTER_LEN = 3,
    parameter logic [7:0] RESET_VAL = 8'h00,
    localparam int PTR_W = $clog2(NUM_REGS)
) (
    input  logic system_clock,
    input  logic reset_n,
    input  logic sda_in,
    input  logic scl_in,
    output logic sda_oe,
    output logic busy,
    output logic wr_strobe,
    output logic [PTR_W-1:0] wr_addr,
    output logic [7:0] wr_data,
    input  logic [PTR_W-1:0] host_addr,
    output logic [7:0] host_rdata
);
`ifdef I2C_GENERAL_CALL_EN
    localparam bit GC_EN = 1'b1;
`else
    localparam bit GC_EN = 1'b0;
`endif
    logic sda_f, sda_rise, sda_fall, scl_f, scl_rise, scl_fall;
    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda (.system_clock(system_clock), .reset_n(reset_n),
        .pin(sda_in), .level(sda_f), .rise(sda_rise), .fall(sda_fall));
    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl (.system_clock(system_clock), .reset_n(reset_n),
        .pin(scl_in), .level(scl_f), .rise(scl_rise), .fall(scl_fall));
    i2c_tgt_state_e state;
    logic [7:0] regs [NUM_REGS];
    logic [7:0] shift;
    logic [2:0] bitcnt;
    logic [PTR_W-1:0] pointer;
    logic gc;
    logic start, stop, last, addr_hit, gc_hit, ptr_ok;
    logic [7:0] byte_in;
    logic [PTR_W-1:0] ptr_next;
    assign start = sda_fall & scl_f;
    assign stop = sda_rise & scl_f;
    assign byte_in = {shift[6:0], sda_f};
    assign last = bitcnt == 3'd7;
    assign addr_hit = byte_in[7:1] == TARGET_ADDR;
    assign gc_hit = GC_EN && byte_in == {GEN_CALL_ADDR, 1'b0};
    assign ptr_ok = {1'b0, byte_in} < 9'(NUM_REGS);
    assign ptr_next = pointer == PTR_W'(NUM_REGS - 1) ? '0 : pointer + 1'b1;
    assign host_rdata = regs[host_addr];
    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            sda_oe <= 1'b0;
            busy <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            pointer <= '0;
            shift <= '0;
            bitcnt <= '0;
            gc <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
        end else begin
            wr_strobe <= 1'b0;
            if (start) begin
                state <= ADDR;
                bitcnt <= '0;
                busy <= 1'b1;
                sda_oe <= 1'b0;
                gc <= 1'b0;
            end else if (stop) begin
                state <= IDLE;
                busy <= 1'b0;
                sda_oe <= 1'b0;
            end else if (scl_fall) begin
                // SDA only changes while SCL is low: ACK slots pull low, read bits drive inverted data.
                sda_oe <= state inside {ADDR_ACK, PTR_ACK, WDATA_ACK} ? ~I2C_ACK :
                          state == RDATA ? ~shift[7] : 1'b0;
            end else if (scl_rise) begin
                case (state)
                    ADDR: begin
                        shift <= byte_in;
                        bitcnt <= bitcnt + 1'b1;
                        if (last) begin
                            state <= (addr_hit || gc_hit) ? ADDR_ACK : IGNORE;
                            gc <= gc_hit;
                        end
                    end
                    ADDR_ACK: begin
                        state <= shift[0] ? RDATA : PTR;
                        if (shift[0]) shift <= regs[pointer];
                    end
                    PTR: begin
                        shift <= byte_in;
                        bitcnt <= bitcnt + 1'b1;
                        if (last && gc) begin
                            state <= PTR_ACK;
                            if (byte_in == GEN_CALL_RESET) begin
                                pointer <= '0;
                                for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
                            end
                        end else if (last) begin
                            state <= ptr_ok ? PTR_ACK : IGNORE;
                            if (ptr_ok) pointer <= byte_in[PTR_W-1:0];
                        end
                    end
                    PTR_ACK: state <= gc ? IGNORE : WDATA;
                    WDATA: begin
                        shift <= byte_in;
                        bitcnt <= bitcnt + 1'b1;
                        if (last) begin
                            regs[pointer] <= byte_in;
                            wr_strobe <= 1'b1;
                            wr_addr <= pointer;
                            wr_data <= byte_in;
                            pointer <= ptr_next;
                            state <= WDATA_ACK;
                        end
                    end
                    WDATA_ACK: state <= WDATA;
                    RDATA: begin
                        shift <= {shift[6:0], 1'b0};
                        bitcnt <= bitcnt + 1'b1;
                        if (last) begin
                            pointer <= ptr_next;
                            state <= RACK;
                        end
                    end
                    RACK: begin
                        state <= (sda_f == I2C_NACK) ? IGNORE : RDATA;
                        shift <= regs[pointer];
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_target_regfile.sv
// tb_i2c_target_regfile: directed I2C master transactions against the register-file target.
module tb_i2c_target_regfile;
    localparam int Q = 10;
    logic system_clock = 1'b0;
    logic reset_n = 1'b0;
    logic m_sda = 1'b1;
    logic m_scl = 1'b1;
    logic [3:0] host_addr = '0;
    logic sda_oe, busy, wr_strobe, sda_bus;
    logic [3:0] wr_addr;
    logic [7:0] wr_data, host_rdata;
    int total = 0;
    int bad = 0;
    logic [11:0] wq[$];
    assign sda_bus = m_sda & ~sda_oe;
    always #5 system_clock = ~system_clock;
    i2c_target_regfile dut (
        .system_clock(system_clock), .reset_n(reset_n), .sda_in(sda_bus), .scl_in(m_scl),
        .sda_oe(sda_oe), .busy(busy), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
        .host_addr(host_addr), .host_rdata(host_rdata)
    );
    always @(negedge system_clock) if (reset_n && wr_strobe) wq.push_back({wr_addr, wr_data});
    task automatic cyc(input int n);
        repeat (n) @(negedge system_clock);
    endtask
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic rd_reg(input logic [3:0] a, output logic [7:0] v);
        host_addr = a;
        #1 v = host_rdata;
    endtask
    task automatic start_c();
        m_sda = 1'b1; cyc(Q);
        m_scl = 1'b1; cyc(Q);
        m_sda = 1'b0; cyc(Q);
        m_scl = 1'b0; cyc(Q);
    endtask
    task automatic stop_c();
        m_sda = 1'b0; cyc(Q);
        m_scl = 1'b1; cyc(Q);
        m_sda = 1'b1; cyc(Q);
    endtask
    task automatic clk_bit(input logic b, input bit glitch, output logic s);
        m_sda = b; cyc(Q);
        m_scl = 1'b1; cyc(Q);
        s = sda_bus;
        if (glitch) begin
            m_scl = 1'b0; cyc(1);
            m_scl = 1'b1;
        end
        cyc(Q);
        m_scl = 1'b0; cyc(Q);
    endtask
    task automatic send(input logic [7:0] b, input bit glitch, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], glitch && i == 7, s);
        clk_bit(1'b1, 1'b0, ack);
    endtask
    task automatic recv(input logic ack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(1'b1, 1'b0, b[i]);
        clk_bit(ack, 1'b0, s);
    endtask
    task automatic wr1(input logic [7:0] p, input logic [7:0] d);
        logic a;
        start_c();
        send(8'hA0, 0, a);
        send(p, 0, a);
        send(d, 0, a);
        stop_c();
    endtask
    initial begin
        logic a;
        logic [7:0] v;
        cyc(3);
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wr_strobe", wr_strobe, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        rd_reg(4'd5, v); chk("rst_reg5", v, 8'h00);
        reset_n = 1'b1;
        cyc(5);
        // Basic write of two bytes from pointer 3
        start_c();
        chk("t1_busy_start", busy, 1);
        send(8'hA0, 0, a); chk("t1_addr_ack", a, 0);
        send(8'h03, 0, a); chk("t1_ptr_ack", a, 0);
        send(8'hAA, 0, a); chk("t1_d0_ack", a, 0);
        send(8'hBB, 0, a); chk("t1_d1_ack", a, 0);
        stop_c();
        chk("t1_busy_stop", busy, 0);
        chk("t1_nstrobe", wq.size(), 2);
        if (wq.size() == 2) begin
            chk("t1_strobe0", wq[0], 12'h3AA);
            chk("t1_strobe1", wq[1], 12'h4BB);
        end
        rd_reg(4'd4, v); chk("t1_reg4", v, 8'hBB);
        rd_reg(4'd3, v); chk("t1_reg3", v, 8'hAA);
        // Pointer wrap from 15 to 0
        wr1(8'h01, 8'h5A);
        wr1(8'h0E, 8'h77);
        wq.delete();
        start_c();
        send(8'hA0, 0, a);
        send(8'h0F, 0, a);
        send(8'h11, 0, a); chk("t2_d0_ack", a, 0);
        send(8'h22, 0, a); chk("t2_d1_ack", a, 0);
        stop_c();
        rd_reg(4'd15, v); chk("t2_reg15", v, 8'h11);
        rd_reg(4'd0, v); chk("t2_reg0", v, 8'h22);
        if (wq.size() == 2) chk("t2_strobe1", wq[1], 12'h022);
        else chk("t2_nstrobe", wq.size(), 2);
        start_c();
        send(8'hA1, 0, a); chk("t2_rd_ack", a, 0);
        recv(1'b1, v); chk("t2_ptr1_read", v, 8'h5A);
        stop_c();
        // Repeated START read across the wrap
        start_c();
        send(8'hA0, 0, a);
        send(8'h0E, 0, a); chk("t3_ptr_ack", a, 0);
        start_c();
        send(8'hA1, 0, a); chk("t3_addr_ack", a, 0);
        recv(1'b0, v); chk("t3_rd14", v, 8'h77);
        recv(1'b0, v); chk("t3_rd15", v, 8'h11);
        recv(1'b1, v); chk("t3_rd0", v, 8'h22);
        chk("t3_release", sda_oe, 0);
        stop_c();
        chk("t3_busy", busy, 0);
        // Foreign address and out-of-range pointer
        wq.delete();
        start_c();
        send(8'hA2, 0, a); chk("t4_addr_nack", a, 1);
        send(8'h03, 0, a); chk("t4_ign_nack", a, 1);
        chk("t4_busy", busy, 1);
        stop_c();
        chk("t4_busy_stop", busy, 0);
        start_c();
        send(8'hA0, 0, a);
        send(8'h20, 0, a); chk("t4_ptr_nack", a, 1);
        send(8'h99, 0, a); chk("t4_data_nack", a, 1);
        stop_c();
        chk("t4_nstrobe", wq.size(), 0);
        rd_reg(4'd0, v); chk("t4_reg0", v, 8'h22);
        // SCL glitch during a data bit
        start_c();
        send(8'hA0, 0, a);
        send(8'h03, 0, a);
        send(8'hC3, 1, a); chk("t5_glitch_ack", a, 0);
        stop_c();
        rd_reg(4'd3, v); chk("t5_reg3", v, 8'hC3);
        // Reset in the middle of a data byte
        start_c();
        send(8'hA0, 0, a);
        send(8'h05, 0, a);
        for (int i = 0; i < 4; i++) clk_bit(1'b1, 0, a);
        reset_n = 1'b0;
        cyc(2);
        chk("t5_rst_sda_oe", sda_oe, 0);
        chk("t5_rst_busy", busy, 0);
        rd_reg(4'd3, v); chk("t5_rst_reg3", v, 8'h00);
        rd_reg(4'd15, v); chk("t5_rst_reg15", v, 8'h00);
        reset_n = 1'b1;
        cyc(5);
        stop_c();
        wq.delete();
        start_c();
        send(8'hA0, 0, a); chk("t5_post_ack", a, 0);
        send(8'h02, 0, a);
        send(8'h44, 0, a);
        stop_c();
        rd_reg(4'd2, v); chk("t5_post_reg2", v, 8'h44);
        if (wq.size() == 1) chk("t5_post_strobe", wq[0], 12'h244);
        else chk("t5_post_nstrobe", wq.size(), 1);
        // General call
        start_c();
        send(8'h00, 0, a);
`ifdef I2C_GENERAL_CALL_EN
        chk("t6_gc_addr", a, 0);
        send(8'h06, 0, a); chk("t6_gc_cmd", a, 0);
        stop_c();
        rd_reg(4'd2, v); chk("t6_gc_reg2", v, 8'h00);
`else
        chk("t6_gc_addr", a, 1);
        send(8'h06, 0, a); chk("t6_gc_cmd", a, 1);
        stop_c();
        rd_reg(4'd2, v); chk("t6_gc_reg2", v, 8'h44);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
